down_fifo_reader: RTL



---
 rtl/down_fifo_reader_pkg.sv | 20 ++
 rtl/down_fifo_reader_if.sv | 26 ++
 rtl/fifo_skid_buf.sv | 54 +++++
 rtl/down_fifo_reader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/down_fifo_reader_pkg.sv
// Shared types for the downscale-path FIFO reader.
// State encoding, pixel width and the output beat bundle.
package down_fifo_pkg;

   localparam int PIX_W = 24;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } rd_state_e;

   typedef struct packed {
      logic [PIX_W-1:0] data;
      logic             sof;
      logic             eol;
      logic             eof;
   } pix_beat_t;

endpackage

// File: rtl/down_fifo_reader_if.sv
// FIFO read port plus framed pixel stream of the reader.
// master is the reader side, slave is the FIFO/sink side.
interface down_fifo_reader_if #(
   parameter int DATA_WIDTH = down_fifo_pkg::PIX_W
);
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  fifo_almost_empty;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_sof;
   logic                  m_eol;
   logic                  m_eof;

   modport master (
      output fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
      input  fifo_rd_data, fifo_empty, fifo_almost_empty, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
      output fifo_rd_data, fifo_empty, fifo_almost_empty, m_ready
   );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO absorbing the FIFO read latency.
// Simultaneous push and pop keep occupancy and order.
module fifo_skid_buf #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   occ_q;
   logic [1:0]   occ_d;

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_d;
      end
   end

   assign dout = mem_q[rd_ptr_q];
   assign occ  = occ_q;

   a_no_ovf: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && occ_q == 2'd2));
   a_no_udf: assert property (@(posedge clk) disable iff (rst)
      !(pop && occ_q == 2'd0));

endmodule

// File: rtl/down_fifo_reader.sv
// Drains the pixel async FIFO into a framed valid/ready stream.
// Reads are credit-limited so the skid buffer never overflows.
module down_fifo_reader
   import down_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = PIX_W,
   parameter int CNT_WIDTH  = 12,
   parameter int UND_WIDTH  = 16
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 frame_start,
   input  logic [CNT_WIDTH-1:0] h_size,
   input  logic [CNT_WIDTH-1:0] v_size,
   down_fifo_reader_if.master   bus,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 cfg_err,
   output logic [UND_WIDTH-1:0] underrun_cnt
);
   localparam int TW = 2 * CNT_WIDTH;

   rd_state_e             state_q;
   logic [CNT_WIDTH-1:0]  h_q, v_q, x_q, y_q;
   logic [TW-1:0]         total_q, rcnt_q;
   logic [UND_WIDTH-1:0]  und_q;
   logic                  inflight_q, frame_done_q, cfg_err_q;
   logic [DATA_WIDTH-1:0] head;
   logic [1:0]            occ;
   logic [2:0]            credit;
   logic                  valid, pop, rd_en, eol, eof;
   pix_beat_t             beat;
   logic                  unused_almost_empty;

   assign unused_almost_empty = bus.fifo_almost_empty;

   assign valid  = (occ != 2'd0);
   assign pop    = valid & bus.m_ready;
   // buffered + in flight, after this cycle's pop
   assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en  = (state_q == RUN) & ~bus.fifo_empty
                 & (rcnt_q < total_q) & (credit < 3'd2);

   assign eol = (x_q == h_q - CNT_WIDTH'(1));
   assign eof = eol & (y_q == v_q - CNT_WIDTH'(1));

   fifo_skid_buf #(.W(DATA_WIDTH)) u_skid (
      .clk  (rd_clk),
      .rst  (rd_rst),
      .push (inflight_q),
      .pop  (pop),
      .din  (bus.fifo_rd_data),
      .dout (head),
      .occ  (occ)
   );

   always_comb begin
      beat = '0;
      if (valid) begin
         beat.data = head;
         beat.sof  = (x_q == '0) && (y_q == '0);
         beat.eol  = eol;
         beat.eof  = eof;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q      <= IDLE;
         h_q          <= '0;
         v_q          <= '0;
         total_q      <= '0;
         rcnt_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         und_q        <= '0;
         inflight_q   <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         inflight_q   <= rd_en;
         frame_done_q <= pop & eof;
         cfg_err_q    <= 1'b0;
         if (rd_en) rcnt_q <= rcnt_q + TW'(1);
         if (pop) begin
            if (eof) begin
               x_q <= '0;
               y_q <= '0;
            end else if (eol) begin
               x_q <= '0;
               y_q <= y_q + CNT_WIDTH'(1);
            end else begin
               x_q <= x_q + CNT_WIDTH'(1);
            end
         end
         unique case (state_q)
            IDLE: begin
               if (frame_start) begin
                  if (h_size != '0 && v_size != '0) begin
                     state_q <= RUN;
                     h_q     <= h_size;
                     v_q     <= v_size;
                     total_q <= TW'(h_size) * TW'(v_size);
                     rcnt_q  <= '0;
                     x_q     <= '0;
                     y_q     <= '0;
                     und_q   <= '0;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (rd_en && (rcnt_q + TW'(1) == total_q)) state_q <= FLUSH;
               if (bus.m_ready && !valid && und_q != '1)
                  und_q <= und_q + UND_WIDTH'(1);
            end
            FLUSH: begin
               if (pop && eof) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = valid;
   assign bus.m_data     = beat.data;
   assign bus.m_sof      = beat.sof;
   assign bus.m_eol      = beat.eol;
   assign bus.m_eof      = beat.eof;
   assign busy           = (state_q != IDLE);
   assign frame_done     = frame_done_q;
   assign cfg_err        = cfg_err_q;
   assign underrun_cnt   = und_q;

   a_no_empty_rd: assert property (@(posedge rd_clk) disable iff (rd_rst)
      !(rd_en && bus.fifo_empty));

endmodule
